// File: rtl/event_sink_pkg.sv
// rtl/event_sink_pkg.sv - shared FSM encoding and default parameters for event_sink
package event_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 1000000;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser with rising-edge detect
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_q,
    output logic rise_edge
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
            prev_r <= sync_r[STAGES-1];
        end
    end

    // sync_q comes straight off a flop, so it is safe to return as a registered ack
    assign sync_q    = sync_r[STAGES-1];
    assign rise_edge = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/event_sink.sv
// rtl/event_sink.sv - clocked receiver for a self-timed event link with counter and stall watchdog
module event_sink
    import event_sink_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fire_in,
    output logic             ack,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             overflow,
    output logic             level_out,
    output logic             stall
);

    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic             rise;
    state_t           state;
    logic [TMR_W-1:0] timer;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (fire_in),
        .sync_q    (ack),
        .rise_edge (rise)
    );

    // clear shares the reset path here; the synchroniser only sees rst so ack keeps tracking fire_in
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= ST_IDLE;
            timer       <= '0;
            event_pulse <= 1'b0;
            event_cnt   <= '0;
            overflow    <= 1'b0;
            level_out   <= 1'b0;
            stall       <= 1'b0;
        end else begin
            event_pulse <= rise;
            if (rise) begin
                event_cnt <= event_cnt + 1'b1;
                if (&event_cnt) begin
                    overflow <= 1'b1;
                end
                level_out <= ~level_out;
                timer     <= '0;
                state     <= ST_RUN;
                stall     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        timer <= '0;
                    end
                    ST_RUN: begin
                        if (timer == TMR_LAST) begin
                            state <= ST_STALL;
                            stall <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_STALL: begin
                        stall <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                        stall <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_event_sink.sv
// tb/tb_event_sink.sv - self-checking bench for event_sink against a behavioural model
module tb_event_sink;

    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 20;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             fire_in = 1'b0;
    logic             ack;
    logic             event_pulse;
    logic [CNT_W-1:0] event_cnt;
    logic             overflow;
    logic             level_out;
    logic             stall;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulse_seen = 0;
    int pulse_cyc = 0;

    // Reference model: fire_in sample history (newest first) plus event-level bookkeeping
    bit hist [4];
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_lvl = 1'b0;
    bit m_pulse = 1'b0;
    bit m_run = 1'b0;
    int m_idle = 0;

    always #5 clk = ~clk;

    event_sink #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .fire_in     (fire_in),
        .ack         (ack),
        .event_pulse (event_pulse),
        .event_cnt   (event_cnt),
        .overflow    (overflow),
        .level_out   (level_out),
        .stall       (stall)
    );

    always @(posedge clk) begin : model
        bit e;
        cyc = cyc + 1;
        if (event_pulse === 1'b1) pulse_seen = pulse_seen + 1;
        e = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            m_cnt = 0; m_ovf = 0; m_lvl = 0; m_pulse = 0; m_run = 0; m_idle = 0;
        end else begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = fire_in;
            if (clear) begin
                m_cnt = 0; m_ovf = 0; m_lvl = 0; m_pulse = 0; m_run = 0; m_idle = 0;
            end else if (e) begin
                m_pulse = 1;
                if (m_cnt == CMAX) m_ovf = 1;
                m_cnt = (m_cnt + 1) % (CMAX + 1);
                m_lvl = !m_lvl;
                m_run = 1;
                m_idle = 0;
            end else begin
                m_pulse = 0;
                if (m_run && m_idle < TIMEOUT) m_idle = m_idle + 1;
            end
        end
    end

    function automatic bit m_stall();
        return m_run && (m_idle >= TIMEOUT);
    endfunction

    task automatic pulse_fire(input int hi, input int lo);
        fire_in = 1'b1;
        repeat (hi) @(negedge clk);
        fire_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (event_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", event_pulse); end
        checks++; if (event_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", event_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", level_out); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst = 1'b0;
    endtask

    task automatic test_basic_event();
        @(negedge clk);
        fire_in = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_early: got %b expected 0", ack); end
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack: got %b expected 1", ack); end
        checks++; if (event_pulse !== 1'b0) begin errors++; $display("FAIL basic_pulse_early: got %b expected 0", event_pulse); end
        @(negedge clk);
        pulse_cyc = cyc;
        checks++; if (event_pulse !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %b expected 1", event_pulse); end
        checks++; if (event_cnt !== 4'd1) begin errors++; $display("FAIL basic_cnt: got %0d expected 1", event_cnt); end
        checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL basic_level: got %b expected 1", level_out); end
        @(negedge clk);
        checks++; if (event_pulse !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", event_pulse); end
        fire_in = 1'b0;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_hold: got %b expected 1", ack); end
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_fall: got %b expected 0", ack); end
    endtask

    task automatic test_stall_recovery();
        int n;
        bit was_stall;
        n = 0;
        while (stall !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (stall !== 1'b1 || (cyc - pulse_cyc) != TIMEOUT) begin
            errors++;
            $display("FAIL stall_delay: got stall=%b after %0d cycles expected 1 after %0d", stall, cyc - pulse_cyc, TIMEOUT);
        end
        repeat (5) @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b expected 1", stall); end
        fire_in = 1'b1;
        n = 0;
        was_stall = 1'b0;
        while (event_pulse !== 1'b1 && n < 20) begin
            was_stall = stall;
            @(negedge clk);
            n++;
        end
        checks++; if (was_stall !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL stall_recover: got before=%b now=%b expected before=1 now=0", was_stall, stall); end
        checks++; if (event_cnt !== 4'd2) begin errors++; $display("FAIL stall_cnt: got %0d expected 2", event_cnt); end
        fire_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_burst();
        int p0;
        do_clear();
        p0 = pulse_seen;
        repeat (10) pulse_fire(3, 3);
        @(negedge clk);
        checks++; if (pulse_seen - p0 != 10) begin errors++; $display("FAIL burst_pulses: got %0d expected 10", pulse_seen - p0); end
        checks++; if (event_cnt !== 4'd10) begin errors++; $display("FAIL burst_cnt: got %0d expected 10", event_cnt); end
        checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL burst_level: got %b expected 0", level_out); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL burst_stall: got %b expected 0", stall); end
    endtask

    task automatic test_wrap();
        do_clear();
        repeat (15) pulse_fire(3, 3);
        checks++; if (event_cnt !== 4'd15 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_15: got cnt=%0d ovf=%b expected cnt=15 ovf=0", event_cnt, overflow); end
        pulse_fire(3, 3);
        checks++; if (event_cnt !== 4'd0 || overflow !== 1'b1) begin errors++; $display("FAIL wrap_16: got cnt=%0d ovf=%b expected cnt=0 ovf=1", event_cnt, overflow); end
        pulse_fire(3, 3);
        checks++; if (event_cnt !== 4'd1 || overflow !== 1'b1 || level_out !== 1'b1) begin errors++; $display("FAIL wrap_17: got cnt=%0d ovf=%b lvl=%b expected 1 1 1", event_cnt, overflow, level_out); end
        do_clear();
        checks++; if (event_cnt !== 4'd0 || overflow !== 1'b0 || level_out !== 1'b0) begin errors++; $display("FAIL wrap_clear: got cnt=%0d ovf=%b lvl=%b expected 0 0 0", event_cnt, overflow, level_out); end
        repeat (TIMEOUT + 10) @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wrap_idle_no_stall: got %b expected 0", stall); end
    endtask

    task automatic test_clear_collision();
        int p0;
        p0 = pulse_seen;
        fire_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL coll_ack_rise: got %b expected 1", ack); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (event_pulse !== 1'b0 || event_cnt !== 4'd0) begin errors++; $display("FAIL coll_dropped: got pulse=%b cnt=%0d expected 0 0", event_pulse, event_cnt); end
        @(negedge clk);
        checks++; if (event_pulse !== 1'b0 || ack !== 1'b1) begin errors++; $display("FAIL coll_after: got pulse=%b ack=%b expected 0 1", event_pulse, ack); end
        fire_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL coll_ack_fall: got %b expected 0", ack); end
        checks++; if (pulse_seen - p0 != 0) begin errors++; $display("FAIL coll_pulses: got %0d expected 0", pulse_seen - p0); end
        pulse_fire(3, 3);
        checks++; if (event_cnt !== 4'd1) begin errors++; $display("FAIL coll_next_event: got %0d expected 1", event_cnt); end
    endtask

    task automatic test_reset_mid();
        int p0;
        int n;
        do_clear();
        repeat (5) pulse_fire(3, 3);
        checks++; if (event_cnt !== 4'd5) begin errors++; $display("FAIL rmid_setup_cnt: got %0d expected 5", event_cnt); end
        fire_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, event_pulse, event_cnt, overflow, level_out, stall} !== '0) begin
            errors++;
            $display("FAIL rmid_in_reset: got ack=%b pulse=%b cnt=%0d ovf=%b lvl=%b stall=%b expected all 0",
                     ack, event_pulse, event_cnt, overflow, level_out, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        p0 = pulse_seen;
        n = 0;
        while (event_pulse !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (event_pulse !== 1'b1 || event_cnt !== 4'd1 || level_out !== 1'b1) begin errors++; $display("FAIL rmid_recount: got pulse=%b cnt=%0d lvl=%b expected 1 1 1", event_pulse, event_cnt, level_out); end
        fire_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (pulse_seen - p0 != 1) begin errors++; $display("FAIL rmid_pulses: got %0d expected 1", pulse_seen - p0); end
    endtask

    task automatic test_random();
        bit wave [$];
        logic [CNT_W+4:0] exp_v;
        logic [CNT_W+4:0] got_v;
        int nev;
        int p0;
        for (int round = 0; round < 3; round++) begin
            wave.delete();
            nev = $urandom_range(6, 12);
            for (int i = 0; i < nev; i++) begin
                repeat ($urandom_range(2, 5)) wave.push_back(1'b1);
                repeat ($urandom_range(2, 5)) wave.push_back(1'b0);
            end
            repeat ($urandom_range(0, 40)) wave.push_back(1'b0);
            repeat (3) wave.push_back(1'b0);
            p0 = pulse_seen;
            foreach (wave[i]) begin
                exp_v = {hist[SYNC_STAGES-1], m_pulse, CNT_W'(m_cnt), m_ovf, m_lvl, m_stall()};
                got_v = {ack, event_pulse, event_cnt, overflow, level_out, stall};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL random_cycle r%0d i%0d: got %h expected %h (ack,pulse,cnt,ovf,lvl,stall)", round, i, got_v, exp_v);
                end
                fire_in = wave[i];
                @(negedge clk);
            end
            checks++; if (pulse_seen - p0 != nev) begin errors++; $display("FAIL random_pulses r%0d: got %0d expected %0d", round, pulse_seen - p0, nev); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_event();
        test_stall_recovery();
        test_burst();
        test_wrap();
        test_clear_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
